// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants, encodings and helpers for mem_arbiter
package mem_arbiter_pkg;

  // mainmem command encoding on mem_read_write
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // d_size encodings
  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

  // True when the low address bits do not suit the access size.
  // Bytes are always aligned; the illegal size is reported separately.
  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store-lane merge and load shift/mask/zero-extend
//
// Purely combinational.
//   mem_word  : word currently held in mainmem at the aligned address
//   wdata     : store data, right-justified (byte in [7:0], half in [15:0])
//   lane      : byte offset within the word (addr[1:0])
//   size      : access size code
//   merged    : mem_word with the addressed lane(s) replaced by wdata
//   load_data : addressed lane(s) of mem_word, zero-extended
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] size_mask;

  assign shamt = {lane, 3'b000};

  always_comb begin
    size_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: size_mask = 32'h0000_00FF;
      SZ_HALF: size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign load_data = (mem_word >> shamt) & size_mask;
  assign merged    = (mem_word & ~(size_mask << shamt)) | ((wdata & size_mask) << shamt);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IF/D arbiter in front of single-port mainmem
//
// Shares one mainmem port between instruction fetch (IF) and data (D).
// One access is granted per cycle; on a conflict the requester that was not
// granted last wins. Range/alignment/size errors are reported in the response
// and never reach mainmem as a write. Byte and half stores become a
// read-modify-write over two cycles because mainmem only writes whole words.
//
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   if_req_valid/ready      : fetch request handshake, if_addr word address
//   if_rsp_valid/data/err   : fetch response, one cycle after acceptance
//   d_req_valid/ready       : data request handshake
//   d_addr/d_we/d_size/d_wdata : data request payload
//   d_rsp_valid/data/err    : data response (N+1, or N+2 for sub-word stores)
//   mem_address/data_in/read_write : mainmem command, data_out its read word
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  // Highest byte address at which a full word still fits; all sizes use it.
  localparam logic [31:0] LAST_WORD_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

  state_t      state, state_next;
  grant_t      last_grant;

  logic        gnt_if, gnt_d;
  logic [31:0] sel_addr;
  logic        req_err;
  logic        rmw_start;

  logic [31:0] merged_word;
  logic [31:0] load_word;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;

  mem_lane_align u_lane_align (
    .mem_word  (mem_data_out),
    .wdata     (d_wdata),
    .lane      (d_addr[1:0]),
    .size      (d_size),
    .merged    (merged_word),
    .load_data (load_word)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, checks, mainmem command and next state. Every grant and
  // mainmem command is qualified by reset_n so that asserting reset silences
  // the memory port immediately, including an in-flight RMW write.
  always_comb begin
    gnt_if         = 1'b0;
    gnt_d          = 1'b0;
    sel_addr       = d_addr;
    req_err        = 1'b0;
    rmw_start      = 1'b0;
    state_next     = state;
    mem_address    = STARTING_ADDR;
    mem_data_in    = 32'h0;
    mem_read_write = READ;

    case (state)
      IDLE: begin
        if (reset_n) begin
          gnt_if   = if_req_valid && (!d_req_valid || (last_grant == GNT_D));
          gnt_d    = d_req_valid && !gnt_if;
          sel_addr = gnt_if ? if_addr : d_addr;

          if (gnt_if || gnt_d) begin
            req_err = (sel_addr < STARTING_ADDR) || (sel_addr > LAST_WORD_ADDR);
            if (gnt_if) begin
              req_err = req_err || misaligned(sel_addr[1:0], SZ_WORD);
            end else begin
              req_err = req_err || (d_size == SZ_ILLEGAL) || misaligned(sel_addr[1:0], d_size);
            end
            mem_address = {sel_addr[31:2], 2'b00};
          end

          // Errored stores are reads only; mainmem is never written for them.
          if (gnt_d && d_we && !req_err) begin
            if (d_size == SZ_WORD) begin
              mem_read_write = WRITE;
              mem_data_in    = d_wdata;
            end else begin
              rmw_start  = 1'b1;
              state_next = RMW_WR;
            end
          end
        end
      end

      RMW_WR: begin
        state_next = IDLE;
        if (reset_n) begin
          mem_address    = rmw_addr;
          mem_data_in    = rmw_data;
          mem_read_write = WRITE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign if_req_ready = gnt_if;
  assign d_req_ready  = gnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant   <= GNT_D;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rsp_data  <= 32'h0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      d_rsp_data   <= 32'h0;
      rmw_addr     <= STARTING_ADDR;
      rmw_data     <= 32'h0;
    end else begin
      if_rsp_valid <= gnt_if;
      if_rsp_err   <= gnt_if && req_err;
      if_rsp_data  <= (gnt_if && !req_err) ? mem_data_out : 32'h0;

      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      d_rsp_data   <= 32'h0;

      if (state == RMW_WR) begin
        // The merged word is written this cycle; acknowledge the store next.
        d_rsp_valid <= 1'b1;
      end else if (rmw_start) begin
        rmw_addr <= {d_addr[31:2], 2'b00};
        rmw_data <= merged_word;
      end else if (gnt_d) begin
        d_rsp_valid <= 1'b1;
        d_rsp_err   <= req_err;
        d_rsp_data  <= (!d_we && !req_err) ? load_word : 32'h0;
      end

      if (gnt_if) begin
        last_grant <= GNT_IF;
      end else if (gnt_d) begin
        last_grant <= GNT_D;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [31:0] START = 32'h0100_0000;
  localparam logic [31:0] DEPTH = 32'h0010_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = 32'h0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [31:0] d_addr = 32'h0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd2;
  logic [31:0] d_wdata = 32'h0;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;

  int n_cmp = 0;
  int n_bad = 0;

  // mainmem stand-in: combinational read, write on posedge, preload port
  logic [31:0] mainmem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_val = 32'h0;

  // byte-level reference image of the first 4 KB of mainmem
  logic [7:0]  ref_bytes [0:4095];

  assign mem_data_out = mainmem[mem_address[11:2]];

  always @(posedge clock) begin
    if (mem_read_write) mainmem[mem_address[11:2]] <= mem_data_in;
    else if (pre_en) mainmem[pre_idx] <= pre_val;
  end

  always #5 clock = ~clock;

  mem_arbiter #(.STARTING_ADDR(START), .MEM_DEPTH_BYTES(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_size(d_size), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
  );

  // ---------------------------------------------------------------- helpers
  // All tasks start and end just after a posedge (the drive phase).
  task automatic preload(input int idx, input logic [31:0] v);
    pre_idx = idx[9:0];
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clock); #1;
    pre_en  = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_we         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  // A request is rejected when it starts before the window, when a whole
  // word starting there would run past the window, or when it is not a
  // multiple of its own size.
  function automatic bit addr_bad(input logic [31:0] a, input int nbytes);
    longint la = longint'(a);
    return (la < longint'(START)) || (la + 4 > longint'(START) + longint'(DEPTH)) ||
           ((la % nbytes) != 0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int nbytes);
    logic [31:0] v = 32'h0;
    int off = int'(a - START);
    for (int i = 0; i < nbytes; i++) v = v | (32'(ref_bytes[off + i]) << (8 * i));
    return v;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #3;
    n_cmp++; if ({if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err} !== 4'b0) begin
      n_bad++; $display("FAIL reset_rsp_flags: got %b want 0000", {if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}); end
    n_cmp++; if ({if_rsp_data, d_rsp_data} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rsp_data: got %h/%h want 0/0", if_rsp_data, d_rsp_data); end
    n_cmp++; if (mem_read_write !== 1'b0) begin
      n_bad++; $display("FAIL reset_mem_rw: got %b want 0", mem_read_write); end
    n_cmp++; if (mem_address !== START) begin
      n_bad++; $display("FAIL reset_mem_addr: got %h want %h", mem_address, START); end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fetch_b2b();
    preload(0, 32'h0000_0013);
    preload(1, 32'h00a0_0093);
    if_req_valid = 1'b1; if_addr = START;
    @(negedge clock);
    n_cmp++; if ({if_req_ready, mem_address} !== {1'b1, START}) begin
      n_bad++; $display("FAIL fetch_grant: got rdy=%b addr=%h want 1/%h", if_req_ready, mem_address, START); end
    @(posedge clock); #1;
    if_addr = START + 32'd4;
    @(negedge clock);
    n_cmp++; if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {2'b10, 32'h0000_0013}) begin
      n_bad++; $display("FAIL fetch_rsp0: got v=%b e=%b d=%h want 1/0/00000013", if_rsp_valid, if_rsp_err, if_rsp_data); end
    @(posedge clock); #1;
    if_req_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {2'b10, 32'h00a0_0093}) begin
      n_bad++; $display("FAIL fetch_rsp1: got v=%b e=%b d=%h want 1/0/00a00093", if_rsp_valid, if_rsp_err, if_rsp_data); end
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++; if (if_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL fetch_rsp_pulse: got %b want 0", if_rsp_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_alternate();
    do_reset();
    if_req_valid = 1'b1; if_addr = START;
    d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = START + 32'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_cmp++; if ({if_req_ready, d_req_ready} !== {(k % 2 == 0), (k % 2 == 1)}) begin
        n_bad++; $display("FAIL alt_grant[%0d]: got if=%b d=%b", k, if_req_ready, d_req_ready); end
      if (k > 0) begin
        n_cmp++; if ({if_rsp_valid, d_rsp_valid} !== {(k % 2 == 1), (k % 2 == 0)}) begin
          n_bad++; $display("FAIL alt_rsp[%0d]: got if=%b d=%b", k, if_rsp_valid, d_rsp_valid); end
      end
      @(posedge clock); #1;
    end
    idle_inputs();
    @(posedge clock); #1;
  endtask

  task automatic test_byte_store();
    preload(4, 32'h1122_3344);
    d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = START + 32'h11; d_wdata = 32'h0000_00AB;
    @(negedge clock);
    n_cmp++; if ({d_req_ready, mem_read_write} !== 2'b10) begin
      n_bad++; $display("FAIL bst_read_cycle: got rdy=%b rw=%b want 1/0", d_req_ready, mem_read_write); end
    @(posedge clock); #1;
    idle_inputs(); if_req_valid = 1'b1; if_addr = START;
    @(negedge clock);
    n_cmp++; if ({if_req_ready, d_req_ready, mem_read_write} !== 3'b001) begin
      n_bad++; $display("FAIL bst_wr_ctrl: got if=%b d=%b rw=%b want 0/0/1", if_req_ready, d_req_ready, mem_read_write); end
    n_cmp++; if ({mem_address, mem_data_in} !== {START + 32'h10, 32'h1122_AB44}) begin
      n_bad++; $display("FAIL bst_wr_data: got %h/%h want %h/1122ab44", mem_address, mem_data_in, START + 32'h10); end
    n_cmp++; if (d_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL bst_early_rsp: got %b want 0", d_rsp_valid); end
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data, if_req_ready} !== {2'b10, 32'h0, 1'b1}) begin
      n_bad++; $display("FAIL bst_rsp: got v=%b e=%b d=%h ifrdy=%b want 1/0/0/1", d_rsp_valid, d_rsp_err, d_rsp_data, if_req_ready); end
    @(posedge clock); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = START + 32'h10;
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {2'b10, 32'h1122_AB44}) begin
      n_bad++; $display("FAIL bst_readback: got v=%b e=%b d=%h want 1/0/1122ab44", d_rsp_valid, d_rsp_err, d_rsp_data); end
    @(posedge clock); #1;
  endtask

  task automatic test_sub_loads();
    d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = START + 32'h12;
    @(posedge clock); #1;
    d_size = 2'd0; d_addr = START + 32'h13;
    @(negedge clock);
    n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {2'b10, 32'h0000_1122}) begin
      n_bad++; $display("FAIL half_load: got v=%b e=%b d=%h want 1/0/00001122", d_rsp_valid, d_rsp_err, d_rsp_data); end
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {2'b10, 32'h0000_0011}) begin
      n_bad++; $display("FAIL byte_load: got v=%b e=%b d=%h want 1/0/00000011", d_rsp_valid, d_rsp_err, d_rsp_data); end
    @(posedge clock); #1;
  endtask

  task automatic test_errors();
    bit          port [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] addr [4]  = '{START + 32'd2, START - 32'd4, START + DEPTH, START};
    bit          we   [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz   [4]  = '{2'd2, 2'd2, 2'd2, 2'd3};
    for (int i = 0; i < 4; i++) begin
      if (port[i] == 1'b0) begin
        if_req_valid = 1'b1; if_addr = addr[i];
      end else begin
        d_req_valid = 1'b1; d_addr = addr[i]; d_we = we[i]; d_size = sz[i]; d_wdata = 32'hFFFF_FFFF;
      end
      @(negedge clock);
      n_cmp++; if ({mem_read_write, (port[i] ? d_req_ready : if_req_ready)} !== 2'b01) begin
        n_bad++; $display("FAIL err_accept[%0d]: got rw=%b rdy=%b want 0/1", i, mem_read_write, port[i] ? d_req_ready : if_req_ready); end
      @(posedge clock); #1;
      idle_inputs();
      @(negedge clock);
      if (port[i] == 1'b0) begin
        n_cmp++; if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {2'b11, 32'h0}) begin
          n_bad++; $display("FAIL err_rsp[%0d]: got v=%b e=%b d=%h want 1/1/0", i, if_rsp_valid, if_rsp_err, if_rsp_data); end
      end else begin
        n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {2'b11, 32'h0}) begin
          n_bad++; $display("FAIL err_rsp[%0d]: got v=%b e=%b d=%h want 1/1/0", i, d_rsp_valid, d_rsp_err, d_rsp_data); end
      end
      @(posedge clock); #1;
    end
    n_cmp++; if (mainmem[0] !== 32'h0000_0013) begin
      n_bad++; $display("FAIL err_mem_untouched: got %h want 00000013", mainmem[0]); end
  endtask

  task automatic test_reset_mid_rmw();
    preload(5, 32'hCAFE_F00D);
    d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = START + 32'h14; d_wdata = 32'h55;
    @(posedge clock); #1;
    idle_inputs();
    n_cmp++; if (mem_read_write !== 1'b1) begin
      n_bad++; $display("FAIL rmw_in_write: got %b want 1", mem_read_write); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_read_write, mem_address} !== {1'b0, START}) begin
      n_bad++; $display("FAIL rst_rmw_mem: got rw=%b addr=%h want 0/%h", mem_read_write, mem_address, START); end
    n_cmp++; if ({if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err, d_req_ready} !== 5'b0) begin
      n_bad++; $display("FAIL rst_rmw_outs: got %b want 00000", {if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err, d_req_ready}); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    n_cmp++; if (mainmem[5] !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL rst_rmw_word: got %h want cafef00d", mainmem[5]); end
    d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = START + 32'h14;
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {2'b10, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL rst_rmw_after: got v=%b e=%b d=%h want 1/0/cafef00d", d_rsp_valid, d_rsp_err, d_rsp_data); end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int          last = 1;      // 0 = IF granted last, 1 = D
    bit          busy = 1'b0;   // second cycle of a sub-word store
    bit          p_if, p_d, ferr, derr, exp_wr, n_busy;
    int          nb;
    logic [31:0] v;
    logic [33:0] exp_if = '0;   // {valid, err, data}
    logic [33:0] exp_d  = '0;
    do_reset();
    for (int w = 0; w < 16; w++) begin
      v = $urandom;
      preload(w, v);
      for (int b = 0; b < 4; b++) ref_bytes[4 * w + b] = v[8 * b +: 8];
    end
    for (int c = 0; c < 600; c++) begin
      if_req_valid = ($urandom % 4) != 0;
      case ($urandom % 12)
        0: if_addr = START + DEPTH;
        1: if_addr = START + 32'(4 * ($urandom % 16)) + 32'd2;
        default: if_addr = START + 32'(4 * ($urandom % 16));
      endcase
      d_req_valid = ($urandom % 4) != 0;
      d_we = $urandom % 2;
      d_size = (($urandom % 10) == 0) ? 2'd3 : 2'($urandom % 3);
      d_wdata = $urandom;
      case ($urandom % 16)
        0: d_addr = START - 32'd4;
        1: d_addr = START + DEPTH - 32'd2;
        default: d_addr = START + 32'($urandom % 64);
      endcase
      @(negedge clock);
      p_if = !busy && if_req_valid && (!d_req_valid || last == 1);
      p_d  = !busy && d_req_valid && !p_if;
      nb   = 1 << d_size;
      ferr = addr_bad(if_addr, 4);
      derr = (d_size == 2'd3) || addr_bad(d_addr, nb);
      exp_wr = busy || (p_d && d_we && !derr && d_size == 2'd2);
      n_cmp++; if ({if_req_ready, d_req_ready} !== {p_if, p_d}) begin
        n_bad++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, if_req_ready, d_req_ready, p_if, p_d); end
      n_cmp++; if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== exp_if) begin
        n_bad++; $display("FAIL rnd_if_rsp c%0d: got %b/%b/%h want %b/%b/%h", c, if_rsp_valid, if_rsp_err, if_rsp_data, exp_if[33], exp_if[32], exp_if[31:0]); end
      n_cmp++; if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== exp_d) begin
        n_bad++; $display("FAIL rnd_d_rsp c%0d: got %b/%b/%h want %b/%b/%h", c, d_rsp_valid, d_rsp_err, d_rsp_data, exp_d[33], exp_d[32], exp_d[31:0]); end
      n_cmp++; if (mem_read_write !== exp_wr) begin
        n_bad++; $display("FAIL rnd_mem_rw c%0d: got %b want %b", c, mem_read_write, exp_wr); end
      exp_if = {p_if, p_if && ferr, (p_if && !ferr) ? ref_read(if_addr, 4) : 32'h0};
      exp_d  = '0;
      n_busy = 1'b0;
      if (busy) begin
        exp_d = {2'b10, 32'h0};
      end else if (p_d) begin
        if (derr) exp_d = {2'b11, 32'h0};
        else if (d_we) begin
          for (int i = 0; i < nb; i++) ref_bytes[int'(d_addr - START) + i] = d_wdata[8 * i +: 8];
          if (d_size == 2'd2) exp_d = {2'b10, 32'h0};
          else n_busy = 1'b1;
        end else exp_d = {2'b10, ref_read(d_addr, nb)};
      end
      busy = n_busy;
      if (p_if) last = 0;
      else if (p_d) last = 1;
      @(posedge clock); #1;
    end
    idle_inputs();
    @(posedge clock); #1;
    @(posedge clock); #1;
    for (int w = 0; w < 16; w++) begin
      n_cmp++; if (mainmem[w] !== ref_read(START + 32'(4 * w), 4)) begin
        n_bad++; $display("FAIL rnd_final_mem[%0d]: got %h want %h", w, mainmem[w], ref_read(START + 32'(4 * w), 4)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mainmem[i] = 32'h0;
    test_reset();
    test_fetch_b2b();
    test_alternate();
    test_byte_store();
    test_sub_loads();
    test_errors();
    test_reset_mid_rmw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
